div_nb: RTL and testbench
=========================

// Module: div_nb
// PURPOSE
//   Parametrised multi-cycle restoring divider. Successor to the fixed 8-bit divider.
//   Adds: WIDTH generalisation, synchronous reset, divide-by-zero flag and early-out,
//   and an optional signed mode.
//   Sits beside ALU datapaths. Uses a start/ready handshake and computes one quotient bit per clock.
// PARAMETERS
//   WIDTH  8  operand, quotient and remainder width in bits (>=2)
// PORTS
//   clk    in   1      single clock, rising edge
//   rst    in   1      synchronous, active-high reset
//   a      in   WIDTH  dividend, sampled only on the accept edge
//   b      in   WIDTH  divisor, sampled only on the accept edge
//   start  in   1      request; accepted when start=1 and ready=1 at a rising edge
//   quot   out  WIDTH  quotient, registered, held until the next completion
//   rem    out  WIDTH  remainder, registered, held until the next completion
//   dbz    out  1      1 = last completed operation had b==0
//   ready  out  1      1 = idle, outputs valid, new start accepted
//   sgn    in   1      (DIV_SIGNED_EN only) 1 = two's-complement operation
// BEHAVIOUR
//   Reset: state=IDLE, ready=1, quot=0, rem=0, dbz=0, counter=0.
//   - Reset mid-operation aborts the operation; no result is produced.
//   FSM states: IDLE, CALC, FIX (FIX exists only with DIV_SIGNED_EN).
//   IDLE: on accept edge k, latch operands and go to CALC.
//   - Same edge: ready<=0, count<=0. quot/rem/dbz keep their old values until completion.
//   CALC, b==0: early-out on edge k+1.
//   - quot<=all ones, rem<=a, dbz<=1, ready<=1, go to IDLE.
//   CALC, b!=0: one restoring step per edge, k+1..k+WIDTH.
//   - Step: partial remainder = {r,next dividend bit}; subtract b; if no borrow keep the difference, quotient bit=1.
//   - Edge k+WIDTH: quot/rem registered, dbz<=0, ready<=1, go to IDLE.
//   - Unsigned result: ready is low for exactly WIDTH cycles.
//   start while ready=0: ignored, has no effect. a/b may change freely while busy.
//   start held high across completion: re-accepted on the first edge with ready=1.
//   Arithmetic: partial remainder register is WIDTH+1 bits (sign/borrow).
//   - Invariant: a == quot*b + rem, with rem < b.
//   Boundaries:
//   - a<b: quot=0, rem=a.
//   - a==b: quot=1, rem=0.
//   - b==1: quot=a, rem=0.
//   - a=0: quot=0, rem=0.
// CONFIGURATION
//   DIV_SIGNED_EN defined:
//   - Port sgn exists. With sgn=1, |a| and |b| are latched on accept and CALC runs unsigned.
//   - FIX state: one extra edge (ready at k+WIDTH+1) negates quot if sign(a)!=sign(b) and rem if a<0.
//   - Result truncates toward zero; the remainder takes the sign of the dividend.
//   - Overflow (-2^(W-1) / -1): quot=-2^(W-1) (wraps), rem=0, dbz=0.
//   - Signed b==0: same early-out as unsigned (quot=all ones, rem=a raw, dbz=1).
//   - sgn=0: behaviour identical to the macro-undefined build.
//   DIV_SIGNED_EN undefined:
//   - No sgn port, no FIX state; unsigned only.
// STRUCTURE
//   Package div_pkg:
//   - state enum (IDLE/CALC/FIX)
//   - localparam helpers: CNT_W=$clog2(WIDTH+1), DIV_ALL_ONES
//   Sub-module div_step (combinational, parameter WIDTH):
//   - inputs: partial remainder, dividend bit, divisor
//   - outputs: next partial remainder, quotient bit
//   Top keeps the FSM, counter, operand and result registers, and the sign fixup.
// TESTING (WIDTH=8 unless stated; a bench model checks every result)
//   200/7 -> quot=28, rem=4, dbz=0; ready low exactly 8 cycles after accept.
//   13/0 -> quot=0xFF, rem=13, dbz=1; ready low exactly 1 cycle.
//   255/1 -> 255 r0; 5/9 -> 0 r5; 0/3 -> 0 r0; 9/9 -> 1 r0.
//   Busy cases:
//   - start re-pulsed and a/b changed mid-CALC -> result unaffected.
//   - rst at cycle 4 of CALC -> next edge ready=1, quot=rem=dbz=0; a fresh op then completes correctly.
//   DIV_SIGNED_EN, sgn=1:
//   - -7/2 -> quot=0xFD, rem=0xFF; ready low 9 cycles.
//   - -128/-1 -> quot=0x80, rem=0.
//   WIDTH=16: 1000 random ops, ~10% with b==0, back-to-back with start held high -> all match the model.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the div_nb restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } div_state_e;

  // Counter must hold 0..width inclusive.
  function automatic int unsigned div_cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   pr_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   pr_o,
  output logic             q_bit_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  assign shifted = {pr_i, dvd_bit_i};
  assign diff    = shifted - {2'b00, dvs_i};
  // Top bit of the difference is the borrow: set means the divisor did not fit.
  assign q_bit_o = ~diff[WIDTH+1];
  assign pr_o    = q_bit_o ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/div_nb.sv
// Multi-cycle restoring divider with start/ready handshake, one quotient bit per clock.
// Define DIV_SIGNED_EN to add the sgn port and a two's-complement fixup state.
module div_nb
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
`ifdef DIV_SIGNED_EN
  input  logic             sgn,
`endif
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             dbz,
  output logic             ready
);

  localparam int unsigned CntW = div_cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] DivAllOnes = '1;

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   pr_q, pr_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   pr_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] early_rem;

`ifdef DIV_SIGNED_EN
  logic             fix_q, fix_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? ~v + 1'b1 : v;
  endfunction

  assign early_rem = a_raw_q;
`else
  // Dividend register is untouched until the first step, so it still holds raw a.
  assign early_rem = dvd_q;
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .pr_i     (pr_q),
    .dvd_bit_i(dvd_q[WIDTH-1]),
    .dvs_i    (dvs_q),
    .pr_o     (pr_nxt),
    .q_bit_o  (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pr_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      fix_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      a_raw_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      fix_q   <= fix_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      a_raw_q <= a_raw_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    fix_d   = fix_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    a_raw_d = a_raw_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCalc;
          cnt_d   = '0;
          pr_d    = '0;
          dvd_d   = a;
          dvs_d   = b;
`ifdef DIV_SIGNED_EN
          a_raw_d = a;
          fix_d   = sgn;
          negq_d  = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          negr_d  = sgn & a[WIDTH-1];
          if (sgn) begin
            dvd_d = abs_val(a);
            dvs_d = abs_val(b);
          end
`endif
        end
      end
      StCalc: begin
        if (dvs_q == '0) begin
          quot_d  = DivAllOnes;
          rem_d   = early_rem;
          dbz_d   = 1'b1;
          state_d = StIdle;
        end else begin
          pr_d  = pr_nxt;
          dvd_d = {dvd_q[WIDTH-2:0], q_bit};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
`ifdef DIV_SIGNED_EN
            if (fix_q) begin
              state_d = StFix;
            end else begin
              quot_d  = dvd_d;
              rem_d   = pr_nxt[WIDTH-1:0];
              dbz_d   = 1'b0;
              state_d = StIdle;
            end
`else
            quot_d  = dvd_d;
            rem_d   = pr_nxt[WIDTH-1:0];
            dbz_d   = 1'b0;
            state_d = StIdle;
`endif
          end
        end
      end
`ifdef DIV_SIGNED_EN
      StFix: begin
        quot_d  = negq_q ? ~dvd_q + 1'b1 : dvd_q;
        rem_d   = negr_q ? ~pr_q[WIDTH-1:0] + 1'b1 : pr_q[WIDTH-1:0];
        dbz_d   = 1'b0;
        state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready = (state_q == StIdle);
  end

  assign quot = quot_q;
  assign rem  = rem_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_div_nb.sv
// Scoreboard bench for div_nb: directed 8-bit cases plus 1000 back-to-back random 16-bit ops.
// Signed cases are exercised when DIV_SIGNED_EN is defined.
module tb_div_nb;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        d;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  a8, b8, q8, r8;
  logic        st8, dbz8, rdy8;
  logic [15:0] a16, b16, q16, r16;
  logic        st16, dbz16, rdy16;
`ifdef DIV_SIGNED_EN
  logic        sg8, sg16;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb8[$];
  exp_t sb16[$];

  div_nb #(.WIDTH(8)) u_dut8 (
    .clk  (clk),
    .rst  (rst),
    .a    (a8),
    .b    (b8),
    .start(st8),
`ifdef DIV_SIGNED_EN
    .sgn  (sg8),
`endif
    .quot (q8),
    .rem  (r8),
    .dbz  (dbz8),
    .ready(rdy8)
  );

  div_nb #(.WIDTH(16)) u_dut16 (
    .clk  (clk),
    .rst  (rst),
    .a    (a16),
    .b    (b16),
    .start(st16),
`ifdef DIV_SIGNED_EN
    .sgn  (sg16),
`endif
    .quot (q16),
    .rem  (r16),
    .dbz  (dbz16),
    .ready(rdy16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: native integer division, truncating toward zero when signed.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int w,
                                 input logic s);
    exp_t        e;
    longint      ai, bi;
    logic [31:0] mask;
    mask = (32'h1 << w) - 32'h1;
    e.d  = 1'b0;
    if ((b & mask) == 32'h0) begin
      e.q = mask;
      e.r = a & mask;
      e.d = 1'b1;
    end else if (!s) begin
      e.q = (a & mask) / (b & mask);
      e.r = (a & mask) % (b & mask);
    end else begin
      ai = longint'(a & mask);
      bi = longint'(b & mask);
      if (a[w-1]) ai = ai - (longint'(1) << w);
      if (b[w-1]) bi = bi - (longint'(1) << w);
      e.q = 32'(ai / bi) & mask;
      e.r = 32'(ai % bi) & mask;
    end
    return e;
  endfunction

  task automatic sb_cmp(input string tag, input int depth, input exp_t e,
                        input logic [31:0] q, input logic [31:0] r, input logic d);
    check({tag, "_sb"}, 32'(depth), 32'd1);
    check({tag, "_quot"}, q, e.q);
    check({tag, "_rem"}, r, e.r);
    check({tag, "_dbz"}, {31'd0, d}, {31'd0, e.d});
  endtask

  task automatic pop8(input string tag);
    exp_t e;
    int   depth;
    depth = sb8.size();
    if (depth > 0) begin
      e = sb8.pop_front();
      sb_cmp(tag, depth, e, {24'd0, q8}, {24'd0, r8}, dbz8);
    end else begin
      check({tag, "_sb"}, 32'(depth), 32'd1);
    end
  endtask

  // Issue one 8-bit op; with noise, wiggle a/b and re-pulse start while busy.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic s, input bit noise);
    int lat;
    int lat_exp;
    @(negedge clk);
    a8  = a;
    b8  = b;
    st8 = 1'b1;
`ifdef DIV_SIGNED_EN
    sg8 = s;
`endif
    sb8.push_back(model({24'd0, a}, {24'd0, b}, 8, s));
    lat_exp = (b == 8'd0) ? 1 : (s ? 9 : 8);
    @(posedge clk);
    #1;
    st8 = 1'b0;
    check({tag, "_busy"}, {31'd0, rdy8}, 32'd0);
    lat = 0;
    do begin
      if (noise && lat < 3) begin
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        st8 = 1'b1;
      end else begin
        st8 = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end while (!rdy8 && lat < 40);
    st8 = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    pop8(tag);
  endtask

  initial begin
    int   done;
    int   issued;
    int   guard;
    int   depth;
    logic [15:0] ra, rb;
    logic        rs;
    exp_t e;

    rst = 1'b1;
    st8 = 1'b0; a8 = '0; b8 = '0;
    st16 = 1'b0; a16 = '0; b16 = '0;
`ifdef DIV_SIGNED_EN
    sg8 = 1'b0; sg16 = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, rdy8}, 32'd1);
    check("rst_quot", {24'd0, q8}, 32'd0);
    check("rst_rem", {24'd0, r8}, 32'd0);
    check("rst_dbz", {31'd0, dbz8}, 32'd0);
    rst = 1'b0;

    op8("d200_7", 8'd200, 8'd7, 1'b0, 1'b0);
    op8("d13_0", 8'd13, 8'd0, 1'b0, 1'b0);
    op8("d255_1", 8'd255, 8'd1, 1'b0, 1'b0);
    op8("d5_9", 8'd5, 8'd9, 1'b0, 1'b0);
    op8("d0_3", 8'd0, 8'd3, 1'b0, 1'b0);
    op8("d9_9", 8'd9, 8'd9, 1'b0, 1'b0);
    op8("busy200_7", 8'd200, 8'd7, 1'b0, 1'b1);
`ifdef DIV_SIGNED_EN
    op8("s_m7_2", 8'hF9, 8'd2, 1'b1, 1'b0);
    op8("s_m128_m1", 8'h80, 8'hFF, 1'b1, 1'b0);
    op8("s_7_m2", 8'd7, 8'hFE, 1'b1, 1'b0);
    op8("s_m5_0", 8'hFB, 8'd0, 1'b1, 1'b0);
    op8("u_m7_2", 8'hF9, 8'd2, 1'b0, 1'b0);
`endif

    // Abort mid-calculation: the pending result is dropped and outputs clear.
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd3; st8 = 1'b1;
    @(posedge clk);
    #1;
    st8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_ready", {31'd0, rdy8}, 32'd1);
    check("abort_quot", {24'd0, q8}, 32'd0);
    check("abort_rem", {24'd0, r8}, 32'd0);
    check("abort_dbz", {31'd0, dbz8}, 32'd0);
    op8("after_abort", 8'd77, 8'd5, 1'b0, 1'b0);

    // 16-bit back-to-back with start held high; operands are junk while busy.
    done = 0;
    issued = 0;
    guard = 0;
    @(negedge clk);
    while (done < 1000 && guard < 40000) begin
      if (rdy16) begin
        if (issued > done) begin
          depth = sb16.size();
          if (depth > 0) begin
            e = sb16.pop_front();
            sb_cmp("r16", depth, e, {16'd0, q16}, {16'd0, r16}, dbz16);
          end else begin
            check("r16_sb", 32'(depth), 32'd1);
          end
          done++;
        end
        if (issued < 1000) begin
          ra = 16'($urandom);
          rb = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom);
          if ($urandom_range(0, 3) == 0) rb = rb >> 12;
          rs = 1'b0;
`ifdef DIV_SIGNED_EN
          rs = 1'($urandom_range(0, 1));
          sg16 = rs;
`endif
          a16 = ra;
          b16 = rb;
          st16 = 1'b1;
          sb16.push_back(model({16'd0, ra}, {16'd0, rb}, 16, rs));
          issued++;
        end else begin
          st16 = 1'b0;
        end
      end else begin
        a16 = 16'($urandom);
        b16 = 16'($urandom);
      end
      @(negedge clk);
      guard++;
    end
    st16 = 1'b0;
    check("r16_done", 32'(done), 32'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
